cart_mem_arbiter: RTL and testbench
===================================

Name: cart_mem_arbiter

Overview:
- Shares the single-port cartridge memory between two requesters: the ioctl download writer and the console cartridge read path.
- Buffers one download write and back-pressures the loader with ioctl_wait_o while that write is pending.
- Derives the cartridge metadata from committed writes: page count, SG-1000 flag and extra-RAM flag.
- Sits between the emu top level, the cart memory and cv_console.

Parameters:
- ADDR_W, 20, cart memory address width; 1 MiB space.
- RD_LAT, 1, memory read latency in clk_i cycles; legal values 1 or 2.
- MAX_DEFER, 4, cycles a buffered write may be deferred by reads before it takes priority.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- ioctl_download_i  in  1  download in progress.
- ioctl_wr_i  in  1  single-cycle write strobe.
- ioctl_addr_i  in  25  download byte address.
- ioctl_dout_i  in  8  download data.
- ioctl_index_i  in  8  download image index.
- ioctl_wait_o  out  1  loader stall.
- cart_a_i  in  ADDR_W  console read address.
- cart_rd_i  in  1  single-cycle read request.
- cart_d_o  out  8  read data, held until the next read completes.
- cart_valid_o  out  1  one-cycle pulse when cart_d_o updates.
- mem_addr_o  out  ADDR_W  memory address.
- mem_we_o  out  1  memory write enable.
- mem_d_o  out  8  memory write data.
- mem_q_i  in  8  memory read data.
- cart_pages_o  out  6  address bits [19:14] of the last committed write.
- sg1000_o  out  1  SG-1000 image flag.
- extram_o  out  1  SG-1000 extra RAM at 2000-3FFF.
- overrun_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset values:
  - ioctl_wait_o=0, cart_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_d_o=0.
  - cart_d_o=8'hFF, cart_pages_o=0, sg1000_o=0, extram_o=0, overrun_o=0.
  - FSM returns to IDLE and the write buffer is cleared. An asserted reset mid-operation abandons any pending read or write; no cart_valid_o pulse follows.
- Write buffer (1 entry: addr, data, index, valid):
  - ioctl_wr_i with the buffer empty: capture the entry and set ioctl_wait_o=1 from the next cycle until the cycle after the commit.
  - ioctl_wr_i with the buffer full: write dropped, overrun_o=1 (sticky until reset).
- Read latch: cart_rd_i is captured into a 1-entry pending read (address plus flag). A new cart_rd_i while one is pending replaces the address and does not raise an error.
- FSM states: IDLE, READ, READ_WAIT, WRITE.
  - IDLE: a pending read goes to READ; otherwise a valid write goes to WRITE. If both are pending and the defer counter is at least MAX_DEFER, go to WRITE.
  - READ: mem_addr_o=cart address, mem_we_o=0. Go to READ_WAIT, where the FSM stays RD_LAT cycles.
  - READ_WAIT: on the last cycle, cart_d_o<=mem_q_i and cart_valid_o pulses for 1 cycle; return to IDLE. Total latency from cart_rd_i to cart_valid_o is RD_LAT+2 cycles.
  - WRITE: mem_addr_o=buffer addr[ADDR_W-1:0], mem_d_o=buffer data. mem_we_o=1 for exactly 1 cycle unless buffer addr[24:ADDR_W]≠0; in that case the write is dropped but still acknowledged. Clear the buffer and drop ioctl_wait_o next cycle; return to IDLE.
- Defer counter:
  - Counts cycles the write buffer is valid while the FSM is not in WRITE; saturates at MAX_DEFER.
  - Clears on commit.
- Metadata updates, on each WRITE commit, using the buffered values:
  - cart_pages_o<=addr[19:14].
  - If addr==0: extram_o<=0 and sg1000_o<=(index[4:0]==2).
  - If addr[24:13]==1 and sg1000_o (the value after any same-write update): extram_o<=((addr[12:0]==0)|extram_o) & (&data).
- ioctl_download_i gates nothing in the datapath. Its rising edge clears overrun_o.
- Simultaneous cart_rd_i and ioctl_wr_i in IDLE: both are captured and the read is served first, subject to MAX_DEFER.

Decomposition:
- Shared package cv_cart_pkg: FSM state enum, SG1000_INDEX=5'd2, EXTRAM_PAGE=12'd1, PAGE_SHIFT=14.
- One sub-module, cart_meta_tracker: the cart_pages/sg1000/extram update logic, fed by the commit strobe and buffered addr/index/data.

Test Plan:
- Reset: hold reset_n_i=0 -> cart_d_o=FF, ioctl_wait_o=0, all flags 0. Release -> FSM in IDLE, no memory write.
- Single read: memory holds 8'h5A at 0x00123, pulse cart_rd_i with cart_a_i=0x00123 -> cart_valid_o after RD_LAT+2 cycles, cart_d_o=5A, mem_we_o never set.
- Download write: ioctl_wr_i with addr=0x4000, data=0x3C, index=2 -> ioctl_wait_o high, one mem_we_o at 0x4000 with 3C, cart_pages_o=1. Second write while waiting -> overrun_o=1 and that write is not performed.
- SG-1000 extram:
  - index=2 write at addr 0 -> sg1000_o=1.
  - Writes of FF at 0x2000 and 0x2001 -> extram_o=1.
  - Write of 7F at 0x2002 -> extram_o=0.
- Starvation: buffered write with cart_rd_i pulsed every cycle -> write commits within MAX_DEFER plus 1 read service window; reads stay correct.
- Out-of-range: addr=0x100000 -> mem_we_o stays 0, ioctl_wait_o still released, cart_pages_o=0.

Source files
------------

// File: rtl/cv_cart_pkg.sv
// Shared types and constants for the cartridge memory arbiter and its metadata tracker.
package cv_cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_WRITE     = 2'd3
  } cart_state_e;

  localparam logic [4:0]  SG1000_INDEX = 5'd2;
  localparam logic [11:0] EXTRAM_PAGE  = 12'd1;
  localparam int          PAGE_SHIFT   = 14;

endpackage

// File: rtl/cart_meta_tracker.sv
// Derives page count, SG-1000 flag and extra-RAM flag from each committed download write.
module cart_meta_tracker
  import cv_cart_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        commit_i,
  input  logic [24:0] addr_i,
  input  logic [7:0]  index_i,
  input  logic [7:0]  data_i,
  output logic [5:0]  cart_pages_o,
  output logic        sg1000_o,
  output logic        extram_o
);

  logic [5:0] pages_reg;
  logic       sg1000_reg;
  logic       extram_reg;
  logic       sg1000_next;
  logic       unused_index;

  assign unused_index = ^index_i[7:5];

  // The extra-RAM rule looks at the SG-1000 flag as it stands after this same write.
  always_comb begin
    sg1000_next = sg1000_reg;
    if (addr_i == '0) sg1000_next = (index_i[4:0] == SG1000_INDEX);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pages_reg  <= '0;
      sg1000_reg <= 1'b0;
      extram_reg <= 1'b0;
    end else if (commit_i) begin
      pages_reg  <= addr_i[PAGE_SHIFT+5:PAGE_SHIFT];
      sg1000_reg <= sg1000_next;
      if (addr_i == '0) begin
        extram_reg <= 1'b0;
      end else if ((addr_i[24:13] == EXTRAM_PAGE) && sg1000_next) begin
        extram_reg <= ((addr_i[12:0] == '0) | extram_reg) & (&data_i);
      end
    end
  end

  assign cart_pages_o = pages_reg;
  assign sg1000_o     = sg1000_reg;
  assign extram_o     = extram_reg;

endmodule

// File: rtl/cart_mem_arbiter.sv
// Arbitrates the single-port cart memory between the ioctl download writer and console reads,
// with a one-entry write buffer, a one-entry read latch and a defer limit against read starvation.
module cart_mem_arbiter
  import cv_cart_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int RD_LAT    = 1,
  parameter int MAX_DEFER = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ioctl_download_i,
  input  logic              ioctl_wr_i,
  input  logic [24:0]       ioctl_addr_i,
  input  logic [7:0]        ioctl_dout_i,
  input  logic [7:0]        ioctl_index_i,
  output logic              ioctl_wait_o,
  input  logic [ADDR_W-1:0] cart_a_i,
  input  logic              cart_rd_i,
  output logic [7:0]        cart_d_o,
  output logic              cart_valid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_d_o,
  input  logic [7:0]        mem_q_i,
  output logic [5:0]        cart_pages_o,
  output logic              sg1000_o,
  output logic              extram_o,
  output logic              overrun_o
);

  localparam int DEFER_W = $clog2(MAX_DEFER + 1);

  cart_state_e       state_reg;
  logic              wbuf_valid_reg;
  logic [24:0]       wbuf_addr_reg;
  logic [7:0]        wbuf_data_reg;
  logic [7:0]        wbuf_index_reg;
  logic              wait_reg;
  logic              rd_pend_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [1:0]        lat_cnt_reg;
  logic [DEFER_W-1:0] defer_cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_we_reg;
  logic [7:0]        mem_d_reg;
  logic [7:0]        cart_d_reg;
  logic              cart_valid_reg;
  logic              overrun_reg;
  logic              download_reg;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              defer_sat;
  logic              take_read;
  logic              commit;
  logic              in_range;

  // A read arriving this very cycle is served straight from the port, newest address winning.
  always_comb begin
    rd_req      = rd_pend_reg | cart_rd_i;
    rd_req_addr = cart_rd_i ? cart_a_i : rd_addr_reg;
    defer_sat   = (defer_cnt_reg >= DEFER_W'(MAX_DEFER));
    take_read   = (state_reg == ST_IDLE) && rd_req && !(wbuf_valid_reg && defer_sat);
    commit      = (state_reg == ST_WRITE);
    in_range    = (wbuf_addr_reg[24:ADDR_W] == '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= ST_IDLE;
      lat_cnt_reg    <= '0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_d_reg      <= '0;
      cart_d_reg     <= 8'hFF;
      cart_valid_reg <= 1'b0;
    end else begin
      cart_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (take_read) begin
            state_reg    <= ST_READ;
            mem_addr_reg <= rd_req_addr;
          end else if (wbuf_valid_reg) begin
            state_reg    <= ST_WRITE;
            mem_addr_reg <= wbuf_addr_reg[ADDR_W-1:0];
            mem_d_reg    <= wbuf_data_reg;
            mem_we_reg   <= in_range;
          end
        end
        ST_READ: begin
          state_reg   <= ST_READ_WAIT;
          lat_cnt_reg <= '0;
        end
        ST_READ_WAIT: begin
          if (lat_cnt_reg == 2'(RD_LAT - 1)) begin
            cart_d_reg     <= mem_q_i;
            cart_valid_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
          end
        end
        ST_WRITE: begin
          mem_we_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wbuf_valid_reg <= 1'b0;
      wbuf_addr_reg  <= '0;
      wbuf_data_reg  <= '0;
      wbuf_index_reg <= '0;
      wait_reg       <= 1'b0;
      defer_cnt_reg  <= '0;
      rd_pend_reg    <= 1'b0;
      rd_addr_reg    <= '0;
      overrun_reg    <= 1'b0;
      download_reg   <= 1'b0;
    end else begin
      download_reg <= ioctl_download_i;
      if (ioctl_download_i && !download_reg) overrun_reg <= 1'b0;
      if (ioctl_wr_i && wbuf_valid_reg) overrun_reg <= 1'b1;

      if (commit) begin
        wbuf_valid_reg <= 1'b0;
        wait_reg       <= 1'b0;
        defer_cnt_reg  <= '0;
      end else if (wbuf_valid_reg && !defer_sat) begin
        defer_cnt_reg <= defer_cnt_reg + DEFER_W'(1);
      end

      if (ioctl_wr_i && !wbuf_valid_reg) begin
        wbuf_valid_reg <= 1'b1;
        wbuf_addr_reg  <= ioctl_addr_i;
        wbuf_data_reg  <= ioctl_dout_i;
        wbuf_index_reg <= ioctl_index_i;
        wait_reg       <= 1'b1;
      end

      if (take_read) begin
        rd_pend_reg <= 1'b0;
      end else if (cart_rd_i) begin
        rd_pend_reg <= 1'b1;
        rd_addr_reg <= cart_a_i;
      end
    end
  end

  cart_meta_tracker u_meta (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .commit_i     (commit),
    .addr_i       (wbuf_addr_reg),
    .index_i      (wbuf_index_reg),
    .data_i       (wbuf_data_reg),
    .cart_pages_o (cart_pages_o),
    .sg1000_o     (sg1000_o),
    .extram_o     (extram_o)
  );

  assign ioctl_wait_o = wait_reg;
  assign cart_d_o     = cart_d_reg;
  assign cart_valid_o = cart_valid_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_we_o     = mem_we_reg;
  assign mem_d_o      = mem_d_reg;
  assign overrun_o    = overrun_reg;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: stimulus pushes expected reads/writes, a monitor pops and compares.
module tb_cart_mem_arbiter;

  localparam int ADDR_W       = 20;
  localparam int RD_LAT       = 1;
  localparam int MAX_DEFER    = 4;
  localparam int STARVE_BOUND = MAX_DEFER + 2 * (RD_LAT + 2) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              ioctl_download_i = 1'b0;
  logic              ioctl_wr_i = 1'b0;
  logic [24:0]       ioctl_addr_i = '0;
  logic [7:0]        ioctl_dout_i = '0;
  logic [7:0]        ioctl_index_i = '0;
  logic              ioctl_wait_o;
  logic [ADDR_W-1:0] cart_a_i = '0;
  logic              cart_rd_i = 1'b0;
  logic [7:0]        cart_d_o;
  logic              cart_valid_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [7:0]        mem_d_o;
  logic [7:0]        mem_q_i;
  logic [5:0]        cart_pages_o;
  logic              sg1000_o;
  logic              extram_o;
  logic              overrun_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] rd_q[$];
  wr_t        wr_q[$];
  logic [7:0] mon_rd_exp;
  wr_t        mon_wr_exp;

  always #5 clk_i = ~clk_i;

  cart_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .RD_LAT    (RD_LAT),
    .MAX_DEFER (MAX_DEFER)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .ioctl_download_i (ioctl_download_i),
    .ioctl_wr_i       (ioctl_wr_i),
    .ioctl_addr_i     (ioctl_addr_i),
    .ioctl_dout_i     (ioctl_dout_i),
    .ioctl_index_i    (ioctl_index_i),
    .ioctl_wait_o     (ioctl_wait_o),
    .cart_a_i         (cart_a_i),
    .cart_rd_i        (cart_rd_i),
    .cart_d_o         (cart_d_o),
    .cart_valid_o     (cart_valid_o),
    .mem_addr_o       (mem_addr_o),
    .mem_we_o         (mem_we_o),
    .mem_d_o          (mem_d_o),
    .mem_q_i          (mem_q_i),
    .cart_pages_o     (cart_pages_o),
    .sg1000_o         (sg1000_o),
    .extram_o         (extram_o),
    .overrun_o        (overrun_o)
  );

  // Cart memory model with registered read, RD_LAT cycles deep
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] q1, q2;
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_d_o;
    q1 <= mem[mem_addr_o];
    q2 <= q1;
  end
  assign mem_q_i = (RD_LAT == 2) ? q2 : q1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every read response and every memory write must match the head of its queue
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (cart_valid_o) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read_valid: got data %0h, required no response", cart_d_o);
        end else begin
          mon_rd_exp = rd_q.pop_front();
          $display("read  resp data=%02h", cart_d_o);
          check("read_data", 32'(cart_d_o), 32'(mon_rd_exp));
        end
      end
      if (mem_we_o) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_write: got addr %0h data %0h, required no write", mem_addr_o, mem_d_o);
        end else begin
          mon_wr_exp = wr_q.pop_front();
          $display("write mem  addr=%05h data=%02h", mem_addr_o, mem_d_o);
          check("write_addr", 32'(mem_addr_o), 32'(mon_wr_exp.a));
          check("write_data", 32'(mem_d_o), 32'(mon_wr_exp.d));
        end
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    int cyc;
    @(negedge clk_i);
    cart_a_i  = a;
    cart_rd_i = 1'b1;
    rd_q.push_back(exp);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk_i);
      cart_rd_i = 1'b0;
      cyc++;
      if (cart_valid_o) break;
    end
    check("read_latency", 32'(cyc), 32'(RD_LAT + 2));
  endtask

  task automatic do_write(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx,
                          input bit exp_mem);
    int cyc;
    @(negedge clk_i);
    ioctl_wr_i    = 1'b1;
    ioctl_addr_i  = a;
    ioctl_dout_i  = d;
    ioctl_index_i = idx;
    if (exp_mem) wr_q.push_back({a[ADDR_W-1:0], d});
    @(negedge clk_i);
    ioctl_wr_i = 1'b0;
    check("wait_asserted", 32'(ioctl_wait_o), 32'd1);
    cyc = 0;
    while (ioctl_wait_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    check("wait_released", 32'(ioctl_wait_o), 32'd0);
    $display("ioctl write addr=%07h data=%02h idx=%02h", a, d, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required summary");
    $fatal(1, "timeout");
  end

  initial begin
    int commit_cyc;
    mem[20'h00123] = 8'h5A;
    mem[20'h00456] = 8'hC3;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_cart_d", 32'(cart_d_o), 32'hFF);
    check("rst_wait", 32'(ioctl_wait_o), 32'd0);
    check("rst_valid", 32'(cart_valid_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    check("rst_mem_d", 32'(mem_d_o), 32'd0);
    check("rst_pages", 32'(cart_pages_o), 32'd0);
    check("rst_flags", 32'({sg1000_o, extram_o, overrun_o}), 32'd0);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("idle_mem_we", 32'(mem_we_o), 32'd0);

    // Plain reads
    do_read(20'h00123, 8'h5A);
    do_read(20'h00456, 8'hC3);

    // Download write, then read it back
    do_write(25'h0004000, 8'h3C, 8'd2, 1'b1);
    check("pages_4000", 32'(cart_pages_o), 32'd1);
    check("sg_not_set_4000", 32'(sg1000_o), 32'd0);
    do_read(20'h04000, 8'h3C);

    // Second write while the first is buffered is dropped and flagged
    @(negedge clk_i);
    ioctl_wr_i = 1'b1; ioctl_addr_i = 25'h0004100; ioctl_dout_i = 8'h11; ioctl_index_i = 8'd0;
    wr_q.push_back({20'h04100, 8'h11});
    @(negedge clk_i);
    check("ovr_wait_asserted", 32'(ioctl_wait_o), 32'd1);
    ioctl_addr_i = 25'h0004200; ioctl_dout_i = 8'h22;
    @(negedge clk_i);
    ioctl_wr_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("overrun_set", 32'(overrun_o), 32'd1);
    check("ovr_wait_released", 32'(ioctl_wait_o), 32'd0);
    check("ovr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("overrun write dropped addr=04200");

    // Rising edge of download clears the sticky flag
    @(negedge clk_i);
    ioctl_download_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("overrun_cleared", 32'(overrun_o), 32'd0);
    ioctl_download_i = 1'b0;

    // Out-of-range write: acknowledged, no memory write, pages follow addr[19:14]
    do_write(25'h0100000, 8'h77, 8'd0, 1'b0);
    check("oor_pages", 32'(cart_pages_o), 32'd0);

    // SG-1000 detection and extra RAM pattern
    do_write(25'h0000000, 8'hF3, 8'd2, 1'b1);
    check("sg1000_set", 32'(sg1000_o), 32'd1);
    check("extram_cleared_at_0", 32'(extram_o), 32'd0);
    do_write(25'h0002000, 8'hFF, 8'd0, 1'b1);
    check("extram_2000", 32'(extram_o), 32'd1);
    do_write(25'h0002001, 8'hFF, 8'd0, 1'b1);
    check("extram_2001", 32'(extram_o), 32'd1);
    do_write(25'h0002002, 8'h7F, 8'd0, 1'b1);
    check("extram_2002", 32'(extram_o), 32'd0);
    check("pages_2002", 32'(cart_pages_o), 32'd0);

    // Starvation: continuous reads must not block a buffered write forever
    @(negedge clk_i);
    ioctl_wr_i = 1'b1; ioctl_addr_i = 25'h0000300; ioctl_dout_i = 8'hA5; ioctl_index_i = 8'd0;
    wr_q.push_back({20'h00300, 8'hA5});
    cart_a_i = 20'h00123;
    cart_rd_i = 1'b1;
    commit_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      rd_q.push_back(8'h5A);
      @(negedge clk_i);
      ioctl_wr_i = 1'b0;
      if (mem_we_o && commit_cyc == 0) commit_cyc = c;
      if (commit_cyc != 0 && c >= commit_cyc + 4) break;
    end
    cart_rd_i = 1'b0;
    $display("starvation write committed at cycle %0d", commit_cyc);
    check("starve_commit_in_window", 32'(commit_cyc != 0 && commit_cyc <= STARVE_BOUND), 32'd1);
    repeat (2 * (RD_LAT + 2)) @(negedge clk_i);
    rd_q.delete();
    check("starve_wait_released", 32'(ioctl_wait_o), 32'd0);
    check("starve_queue_drained", 32'(wr_q.size()), 32'd0);

    // Reset mid-read: the read is abandoned, no response ever appears
    @(negedge clk_i);
    cart_a_i = 20'h00456;
    cart_rd_i = 1'b1;
    @(negedge clk_i);
    cart_rd_i = 1'b0;
    reset_n_i = 1'b0;
    rd_q.delete();
    @(negedge clk_i);
    check("midrst_valid", 32'(cart_valid_o), 32'd0);
    check("midrst_cart_d", 32'(cart_d_o), 32'hFF);
    check("midrst_flags", 32'({sg1000_o, extram_o, overrun_o}), 32'd0);
    reset_n_i = 1'b1;
    repeat (6) @(negedge clk_i);
    check("midrst_cart_d_held", 32'(cart_d_o), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
